// File: rtl/daq_mode_controller_if.sv
// daq_mode_controller_if
// Bundles the USB-command side (mode requests, acquisition starts) and the
// DAQ-switcher side (gated start, completion, stop, mode select, status)
// of the DAQ-mode controller. The controller connects through the slave
// modport; whatever drives requests and models the switcher uses master.
interface daq_mode_controller_if;
    logic ModeRequest;
    logic ModeRequestValid;
    logic ModeRequestAck;
    logic ModeRequestErr;
    logic UsbAcqStart;
    logic GatedAcqStart;
    logic StartDropped;
    logic AllDone;
    logic StopRequest;
    logic DaqSelect;
    logic SwitchGuard;
    logic Busy;

    modport master (
        output ModeRequest, ModeRequestValid, UsbAcqStart, AllDone,
        input  ModeRequestAck, ModeRequestErr, GatedAcqStart, StartDropped,
        input  StopRequest, DaqSelect, SwitchGuard, Busy
    );

    modport slave (
        input  ModeRequest, ModeRequestValid, UsbAcqStart, AllDone,
        output ModeRequestAck, ModeRequestErr, GatedAcqStart, StartDropped,
        output StopRequest, DaqSelect, SwitchGuard, Busy
    );
endinterface

// File: rtl/daq_mode_controller.sv
// daq_mode_controller
// Sole driver of DaqSelect for the AutoDaq/SlaveDaq switch. Mode changes
// are only made with no acquisition running, surrounded by GUARD_CYCLES
// idle cycles on each side of the select change. All outputs registered.
// Optional feature macro: DAQ_DRAIN_TIMEOUT_EN -- when defined, DRAIN gives
// up after DRAIN_TIMEOUT cycles with a ModeRequestErr pulse; otherwise DRAIN
// waits for AllDone indefinitely and ModeRequestErr stays low.
module daq_mode_controller #(
    parameter int unsigned GUARD_CYCLES  = 16,
    parameter int unsigned DRAIN_TIMEOUT = 65535
) (
    input  logic                        Clk,
    input  logic                        reset,
    daq_mode_controller_if.slave        daqIf
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_DRAIN      = 3'd2,
        ST_GUARD_PRE  = 3'd3,
        ST_GUARD_POST = 3'd4
    } state_t;

    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);
`ifdef DAQ_DRAIN_TIMEOUT_EN
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);
`endif

    state_t      state_r,       nextState_s;
    logic [15:0] count_r,       countNext_s;
    logic        target_r,      nextTarget_s;
    logic        daqSelect_r,   selNext_s;
    logic        ack_r,         ackNext_s;
    logic        err_r,         errNext_s;
    logic        gated_r,       gatedNext_s;
    logic        dropped_r,     droppedNext_s;
    logic        stop_r,        stopNext_s;
    logic        guard_r,       guardNext_s;
    logic        busy_r,        busyNext_s;

    logic        guardDone_s;
    logic        drainExpired_s;
    logic        countEnable_s;
    logic        valid_s;
    logic        start_s;
    logic        done_s;
    logic        req_s;

    assign valid_s = daqIf.ModeRequestValid;
    assign start_s = daqIf.UsbAcqStart;
    assign done_s  = daqIf.AllDone;
    assign req_s   = daqIf.ModeRequest;

    // Last cycle of a guard phase: counter started at 0 on state entry.
    assign guardDone_s = (count_r >= GUARD_LAST);

`ifdef DAQ_DRAIN_TIMEOUT_EN
    assign drainExpired_s = (count_r >= DRAIN_LAST);
    assign countEnable_s  = (state_r == ST_GUARD_PRE) || (state_r == ST_GUARD_POST) ||
                            (state_r == ST_DRAIN);
`else
    assign drainExpired_s = 1'b0;
    assign countEnable_s  = (state_r == ST_GUARD_PRE) || (state_r == ST_GUARD_POST);
`endif

    // State register, shared phase counter, latched target and registered outputs.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= 16'd0;
            target_r    <= 1'b1;
            daqSelect_r <= 1'b1;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            gated_r     <= 1'b0;
            dropped_r   <= 1'b0;
            stop_r      <= 1'b0;
            guard_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= nextState_s;
            count_r     <= countNext_s;
            target_r    <= nextTarget_s;
            daqSelect_r <= selNext_s;
            ack_r       <= ackNext_s;
            err_r       <= errNext_s;
            gated_r     <= gatedNext_s;
            dropped_r   <= droppedNext_s;
            stop_r      <= stopNext_s;
            guard_r     <= guardNext_s;
            busy_r      <= busyNext_s;
        end
    end

    // Next state, next counter value and the effective (possibly overwritten) target.
    always_comb begin
        nextState_s  = state_r;
        nextTarget_s = valid_s ? req_s : target_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_s) begin
                    nextState_s = (req_s != daqSelect_r) ? ST_GUARD_PRE : ST_IDLE;
                end else if (start_s) begin
                    nextState_s = ST_RUN;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A request arriving with AllDone needs no drain: the run is already over.
                if (done_s) begin
                    if (valid_s && (req_s != daqSelect_r)) begin
                        nextState_s = ST_GUARD_PRE;
                    end else begin
                        nextState_s = ST_IDLE;
                    end
                end else if (valid_s) begin
                    nextState_s = ST_DRAIN;
                end else begin
                    nextState_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (done_s) begin
                    nextState_s = (nextTarget_s != daqSelect_r) ? ST_GUARD_PRE : ST_IDLE;
                end else if (drainExpired_s) begin
                    nextState_s = ST_IDLE;
                end else begin
                    nextState_s = ST_DRAIN;
                end
            end
            ST_GUARD_PRE: begin
                nextState_s = guardDone_s ? ST_GUARD_POST : ST_GUARD_PRE;
            end
            ST_GUARD_POST: begin
                if (valid_s && (req_s != daqSelect_r)) begin
                    nextState_s = ST_GUARD_PRE;
                end else if (guardDone_s) begin
                    nextState_s = ST_IDLE;
                end else begin
                    nextState_s = ST_GUARD_POST;
                end
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase

        // Cleared on every state entry, saturating otherwise.
        if ((nextState_s != state_r) || !countEnable_s) begin
            countNext_s = 16'd0;
        end else if (count_r == 16'hFFFF) begin
            countNext_s = count_r;
        end else begin
            countNext_s = count_r + 16'd1;
        end
    end

    // Next values of all registered outputs, derived from the transition taken.
    always_comb begin
        ackNext_s     = 1'b0;
        errNext_s     = 1'b0;
        gatedNext_s   = 1'b0;
        droppedNext_s = 1'b0;
        selNext_s     = daqSelect_r;
        stopNext_s    = (nextState_s == ST_DRAIN);
        guardNext_s   = (nextState_s == ST_GUARD_PRE) || (nextState_s == ST_GUARD_POST);
        busyNext_s    = (nextState_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (valid_s) begin
                    ackNext_s     = (req_s == daqSelect_r);
                    droppedNext_s = start_s;
                end else begin
                    gatedNext_s   = start_s;
                end
            end
            ST_RUN: begin
                droppedNext_s = start_s;
                ackNext_s     = done_s && valid_s && (req_s == daqSelect_r);
            end
            ST_DRAIN: begin
                droppedNext_s = start_s;
                if (done_s) begin
                    ackNext_s = (nextTarget_s == daqSelect_r);
                end else begin
                    errNext_s = drainExpired_s;
                end
            end
            ST_GUARD_PRE: begin
                droppedNext_s = start_s;
                if (guardDone_s) begin
                    selNext_s = nextTarget_s;
                end else begin
                    selNext_s = daqSelect_r;
                end
            end
            ST_GUARD_POST: begin
                droppedNext_s = start_s;
                ackNext_s     = (nextState_s == ST_IDLE);
            end
            default: begin
                ackNext_s = 1'b0;
            end
        endcase
    end

    assign daqIf.ModeRequestAck = ack_r;
    assign daqIf.ModeRequestErr = err_r;
    assign daqIf.GatedAcqStart  = gated_r;
    assign daqIf.StartDropped   = dropped_r;
    assign daqIf.StopRequest    = stop_r;
    assign daqIf.DaqSelect      = daqSelect_r;
    assign daqIf.SwitchGuard    = guard_r;
    assign daqIf.Busy           = busy_r;

endmodule

// File: tb/tb_daq_mode_controller.sv
// tb_daq_mode_controller
// Directed vector table, hand-written multi-cycle sequences and a random
// run checked against a phase-level reference model of the mode controller.
// Observed output vector: {Ack, Err, Gated, Dropped, Stop, Sel, Guard, Busy}.
// Input vector: {reset, ModeRequest, ModeRequestValid, UsbAcqStart, AllDone}.
module tb_daq_mode_controller;
    localparam int G = 4;
    localparam int T = 100;
`ifdef DAQ_DRAIN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [4:0] I_NONE  = 5'b00000;
    localparam logic [4:0] I_RST   = 5'b10000;
    localparam logic [4:0] I_START = 5'b00010;
    localparam logic [4:0] I_DONE  = 5'b00001;
    localparam logic [4:0] I_REQ0  = 5'b00100;
    localparam logic [4:0] I_REQ1  = 5'b01100;

    logic clk = 1'b0;
    logic reset;
    daq_mode_controller_if dif();

    daq_mode_controller #(.GUARD_CYCLES(G), .DRAIN_TIMEOUT(T)) dut (
        .Clk   (clk),
        .reset (reset),
        .daqIf (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] inp;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phases and a countdown of remaining guard cycles.
    localparam int P_IDLE = 0, P_ACQ = 1, P_DRAIN = 2, P_PRE = 3, P_POST = 4;
    int phase = P_IDLE;
    bit mode  = 1'b1;
    bit tgt   = 1'b1;
    int rem   = 0;
    int waited = 0;
    bit ackM, errM, gatedM, dropM;

    task automatic startSwitch();
        if (tgt == mode) begin
            ackM  = 1'b1;
            phase = P_IDLE;
        end else begin
            phase = P_PRE;
            rem   = G;
        end
    endtask

    task automatic modelStep(input logic [4:0] inp);
        bit rst, req, vld, st, done;
        {rst, req, vld, st, done} = inp;
        ackM = 1'b0; errM = 1'b0; gatedM = 1'b0; dropM = 1'b0;
        if (rst) begin
            phase = P_IDLE; mode = 1'b1; rem = 0; waited = 0;
            return;
        end
        if (vld) tgt = req;
        case (phase)
            P_IDLE: begin
                if (vld) begin
                    dropM = st;
                    startSwitch();
                end else if (st) begin
                    gatedM = 1'b1;
                    phase  = P_ACQ;
                end
            end
            P_ACQ: begin
                dropM = st;
                if (done) begin
                    if (vld) startSwitch();
                    else phase = P_IDLE;
                end else if (vld) begin
                    phase = P_DRAIN; waited = 0;
                end
            end
            P_DRAIN: begin
                dropM = st;
                waited++;
                if (done) startSwitch();
                else if (TO_EN && waited >= T) begin
                    errM = 1'b1; phase = P_IDLE;
                end
            end
            P_PRE: begin
                dropM = st;
                rem--;
                if (rem == 0) begin
                    mode = tgt; phase = P_POST; rem = G;
                end
            end
            P_POST: begin
                dropM = st;
                if (vld && req != mode) begin
                    phase = P_PRE; rem = G;
                end else begin
                    rem--;
                    if (rem == 0) begin
                        ackM = 1'b1; phase = P_IDLE;
                    end
                end
            end
            default: phase = P_IDLE;
        endcase
    endtask

    function automatic logic [7:0] modelOut();
        return {ackM, errM, gatedM, dropM, phase == P_DRAIN, mode,
                (phase == P_PRE) || (phase == P_POST), phase != P_IDLE};
    endfunction

    // One clock: drive inputs, advance DUT and model, sample 1 ns after the edge.
    task automatic tick(input logic [4:0] inp, output logic [7:0] obs);
        {reset, dif.ModeRequest, dif.ModeRequestValid, dif.UsbAcqStart, dif.AllDone} = inp;
        @(posedge clk);
        modelStep(inp);
        #1;
        obs = {dif.ModeRequestAck, dif.ModeRequestErr, dif.GatedAcqStart, dif.StartDropped,
               dif.StopRequest, dif.DaqSelect, dif.SwitchGuard, dif.Busy};
    endtask

    task automatic checkVec(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic addRows(input logic [4:0] inp, input logic [7:0] exp, input int n);
        vec_t v;
        v.inp = inp;
        v.exp = exp;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] o;
        int n;
        bit found;

        // Directed table: {inputs, expected outputs after the edge}.
        addRows(I_RST,   8'b0000_0100, 1);   // reset values
        addRows(I_REQ1,  8'b1000_0100, 1);   // same-mode request: Ack next cycle
        addRows(I_NONE,  8'b0000_0100, 1);
        addRows(I_START, 8'b0010_0101, 1);   // forwarded start, RUN
        addRows(I_START, 8'b0001_0101, 1);   // start in RUN dropped
        addRows(I_DONE,  8'b0000_0100, 1);   // back to IDLE
        addRows(I_DONE,  8'b0000_0100, 1);   // AllDone ignored in IDLE
        addRows(5'b01110, 8'b1001_0100, 1);  // request beats start, same mode
        addRows(I_START, 8'b0010_0101, 1);
        addRows(I_REQ0,  8'b0000_1101, 1);   // DRAIN
        addRows(I_START, 8'b0001_1101, 1);   // start dropped in DRAIN
        addRows(I_DONE,  8'b0000_0111, 1);   // into GUARD_PRE
        addRows(I_NONE,  8'b0000_0111, 3);
        addRows(I_NONE,  8'b0000_0011, 4);   // GUARD_POST, select now 0
        addRows(I_NONE,  8'b1000_0000, 1);   // Ack, guard falls
        addRows(I_REQ0,  8'b1000_0000, 1);   // same-mode Ack with select 0
        addRows(I_REQ1,  8'b0000_0011, 2);   // change toward 1 ...
        addRows(I_RST,   8'b0000_0100, 1);   // ... aborted by reset
        addRows(I_NONE,  8'b0000_0100, 10);  // no Ack ever appears
        addRows(I_REQ0,  8'b0000_0111, 1);
        addRows(I_NONE,  8'b0000_0111, 3);
        addRows(I_NONE,  8'b0000_0011, 1);   // first GUARD_POST cycle
        addRows(I_REQ1,  8'b0000_0011, 1);   // differing overwrite restarts PRE
        addRows(I_NONE,  8'b0000_0011, 3);
        addRows(I_NONE,  8'b0000_0111, 4);
        addRows(I_NONE,  8'b1000_0100, 1);   // single Ack for final target
        addRows(5'b00110, 8'b0001_0111, 1);  // start+change request same cycle
        addRows(I_NONE,  8'b0000_0111, 3);
        addRows(I_NONE,  8'b0000_0011, 4);
        addRows(I_NONE,  8'b1000_0000, 1);

        foreach (tbl[i]) begin
            tick(tbl[i].inp, o);
            checkVec($sformatf("table row %0d", i), o, tbl[i].exp);
        end

        // Drain for 20 cycles, late start dropped, then guard sequence and Ack.
        tick(I_RST, o);
        tick(I_START, o);
        tick(I_REQ0, o);
        checkVec("drain stop cycle 1", {7'd0, o[3]}, 8'd1);
        for (int c = 1; c <= 19; c++) begin
            tick((c == 5) ? I_START : I_NONE, o);
            checkVec($sformatf("drain stop cycle %0d", c + 1), {7'd0, o[3]}, 8'd1);
            if (c == 5) checkVec("drain start refused", {6'd0, o[5], o[4]}, 8'b01);
        end
        tick(I_DONE, o);
        checkVec("drain stop falls, guard rises", {6'd0, o[3], o[1]}, 8'b01);
        n = 1; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick(I_NONE, o);
            n++;
            if (o[7]) found = 1'b1;
        end
        checkInt("drain ack latency", n, 2 * G + 1);
        checkVec("drain final select", {7'd0, o[2]}, 8'd0);

`ifdef DAQ_DRAIN_TIMEOUT_EN
        // Drain timeout: Err at cycle T+1 after Valid, mode unchanged, idle.
        tick(I_RST, o);
        tick(I_START, o);
        tick(I_REQ0, o);
        n = 1; found = 1'b0;
        for (int k = 0; k < 2 * T && !found; k++) begin
            tick(I_NONE, o);
            n++;
            if (o[6]) found = 1'b1;
        end
        checkInt("timeout err latency", n, T + 1);
        checkVec("timeout sel/busy/ack", {5'd0, o[7], o[2], o[0]}, 8'b010);
`endif

        // Random stimulus against the reference model.
        for (int i = 0; i < 4000; i++) begin
            logic [4:0] r;
            r = {($urandom_range(0, 255) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 14) == 0)};
            tick(r, o);
            checkVec($sformatf("random cycle %0d", i), o, modelOut());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
